// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
//
// Shared constants for the UART command deframer: the default frame start
// marker, the deframer state encoding, and a small saturating-increment
// helper used for the error counter.
//
// No ports (package).
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

    // Default frame start marker.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Deframer state encoding. These are plain constants rather than an enum
    // so that older tools and mixed-language parents can share the values.
    typedef logic [1:0] deframer_state_t;

    localparam deframer_state_t ST_IDLE    = 2'd0;
    localparam deframer_state_t ST_PAYLOAD = 2'd1;
    localparam deframer_state_t ST_CHECK   = 2'd2;

    // Increment an 8-bit count, holding at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_deframer.sv
// ---------------------------------------------------------------------------
// uart_cmd_deframer
//
// Pulls fixed-length command frames out of a UART byte stream. A frame is
// SYNC_BYTE, then PAYLOAD_BYTES payload bytes, then one checksum byte equal
// to the XOR of the payload bytes. A good frame updates cmd_word and pulses
// cmd_valid; a bad checksum or an inter-byte timeout pulses cmd_err and
// bumps a saturating error counter.
//
// Parameters
//   SYNC_BYTE      frame start marker
//   PAYLOAD_BYTES  payload bytes per frame, legal range 1..8
//   TIMEOUT_CYCLES inter-byte timeout in clk cycles
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   rx_data        received byte from the UART receiver
//   rx_data_fresh  one-cycle strobe marking rx_data valid
//   cmd_word       last good payload, first-received byte in the MSBs
//   cmd_valid      one-cycle strobe marking a new cmd_word
//   cmd_err        one-cycle strobe on checksum error or timeout
//   err_count      saturating count of cmd_err pulses
//   busy           high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_cmd_deframer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         PAYLOAD_BYTES  = 4,
    parameter int         TIMEOUT_CYCLES = 8680
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_data_fresh,
    output logic [8*PAYLOAD_BYTES-1:0]   cmd_word,
    output logic                         cmd_valid,
    output logic                         cmd_err,
    output logic [7:0]                   err_count,
    output logic                         busy
);

    // A one-cycle timeout would make $clog2 return zero, so keep at least
    // one bit of counter.
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);

    deframer_state_t            state;
    deframer_state_t            state_nxt;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_nxt;
    logic [7:0]                 xor_acc;
    logic [7:0]                 xor_nxt;
    logic [8*PAYLOAD_BYTES-1:0] asm_reg;
    logic [8*PAYLOAD_BYTES-1:0] asm_nxt;
    logic [TO_W-1:0]            to_cnt;
    logic [TO_W-1:0]            to_nxt;
    logic                       timeout_hit;
    logic                       word_load;
    logic                       valid_nxt;
    logic                       err_nxt;

    assign busy        = (state != ST_IDLE);
    assign timeout_hit = (to_cnt == TO_LAST);

    // Next-state logic. A fresh byte always takes priority over the timeout,
    // so a byte that lands on the last timeout cycle keeps the frame alive.
    // Because of that priority, a checksum result and a timeout can never
    // fire together, which keeps cmd_valid and cmd_err mutually exclusive.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        xor_nxt   = xor_acc;
        asm_nxt   = asm_reg;
        word_load = 1'b0;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;

        // Counter idles at zero, restarts on every byte, runs otherwise.
        if (state == ST_IDLE || rx_data_fresh) begin
            to_nxt = '0;
        end else begin
            to_nxt = to_cnt + TO_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (rx_data_fresh && rx_data == SYNC_BYTE) begin
                    state_nxt = ST_PAYLOAD;
                    idx_nxt   = '0;
                    xor_nxt   = 8'h00;
                end
            end

            ST_PAYLOAD: begin
                if (rx_data_fresh) begin
                    // Shift in from the LSB end so the first byte ends up on top.
                    asm_nxt       = asm_reg << 8;
                    asm_nxt[7:0]  = rx_data;
                    xor_nxt       = xor_acc ^ rx_data;
                    idx_nxt       = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        state_nxt = ST_CHECK;
                    end
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            ST_CHECK: begin
                if (rx_data_fresh) begin
                    if (rx_data == xor_acc) begin
                        word_load = 1'b1;
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state_nxt == ST_IDLE) begin
            to_nxt = '0;
        end
    end

    // Frame-tracking state and registered outputs. Reset abandons any
    // partial frame silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            xor_acc   <= 8'h00;
            asm_reg   <= '0;
            to_cnt    <= '0;
            cmd_word  <= '0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            err_count <= 8'h00;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            xor_acc   <= xor_nxt;
            asm_reg   <= asm_nxt;
            to_cnt    <= to_nxt;
            cmd_valid <= valid_nxt;
            cmd_err   <= err_nxt;
            if (word_load) begin
                cmd_word <= asm_reg;
            end
            if (err_nxt) begin
                err_count <= sat_inc8(err_count);
            end
        end
    end

endmodule
